// File: rtl/d_latch_bank_pkg.sv
// Shared types and constants for the d_latch_bank capture channels.
// Channel state encoding, mode constants and the hold-counter width helper.
package d_latch_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_HELD  = 2'b10
    } state_e;

    localparam logic MODE_FOLLOW  = 1'b0;
    localparam logic MODE_CAPTURE = 1'b1;

    // A zero hold time still needs a 1-bit counter so the port widths stay legal.
    function automatic int hold_cnt_width(input int hold);
        return (hold == 0) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/d_latch_chan.sv
// One data-capture channel: follow/capture FSM, hold counter and q register.
// Optional change-pulse output enabled by D_LATCH_BANK_CHG_EN.
module d_latch_chan
    import d_latch_bank_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             mode,
    input  logic             arm,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             armed,
    output logic             held,
    output logic             cap
`ifdef D_LATCH_BANK_CHG_EN
    ,
    output logic             chg
`endif
);

    localparam int                CNT_W       = hold_cnt_width(HOLD_CYCLES);
    localparam int                HOLD_LAST_I = (HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_LAST_I);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cap_q, cap_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        cap_d   = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            data_d  = '0;
            cnt_d   = '0;
        end else if (mode == MODE_FOLLOW) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (en) begin
                data_d = d;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                    end
                end
                // A repeated arm outranks the capture, so arm+en here just stays armed.
                ST_ARMED: begin
                    if (!arm && en) begin
                        data_d  = d;
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        cap_d   = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else if ((HOLD_CYCLES != 0) && (cnt_q == HOLD_LAST)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    assign q     = data_q;
    assign armed = (state_q == ST_ARMED);
    assign held  = (state_q == ST_HELD);
    assign cap   = cap_q;

`ifdef D_LATCH_BANK_CHG_EN
    logic chg_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= (data_d != data_q);
        end
    end

    assign chg = chg_q;
`endif

endmodule

// File: rtl/d_latch_bank.sv
// Bank of CHANNELS independent capture channels; this level only slices buses.
// Define D_LATCH_BANK_CHG_EN to add the per-channel chg pulse output.
module d_latch_bank
    import d_latch_bank_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       arm,
    input  logic [CHANNELS-1:0]       clear,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       armed,
    output logic [CHANNELS-1:0]       held,
    output logic [CHANNELS-1:0]       cap
`ifdef D_LATCH_BANK_CHG_EN
    ,
    output logic [CHANNELS-1:0]       chg
`endif
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
`ifdef D_LATCH_BANK_CHG_EN
        d_latch_chan #(
            .WIDTH       (WIDTH),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .d       (d[gi*WIDTH +: WIDTH]),
            .en      (en[gi]),
            .mode    (mode[gi]),
            .arm     (arm[gi]),
            .clear   (clear[gi]),
            .q       (q[gi*WIDTH +: WIDTH]),
            .armed   (armed[gi]),
            .held    (held[gi]),
            .cap     (cap[gi]),
            .chg     (chg[gi])
        );
`else
        d_latch_chan #(
            .WIDTH       (WIDTH),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .d       (d[gi*WIDTH +: WIDTH]),
            .en      (en[gi]),
            .mode    (mode[gi]),
            .arm     (arm[gi]),
            .clear   (clear[gi]),
            .q       (q[gi*WIDTH +: WIDTH]),
            .armed   (armed[gi]),
            .held    (held[gi]),
            .cap     (cap[gi])
        );
`endif
    end

endmodule

// File: tb/tb_d_latch_bank.sv
// Bench for d_latch_bank: two instances (hold 3 and hold-forever) driven with
// identical directed and random stimulus, checked against a behavioural model.
module tb_d_latch_bank;

    localparam int W  = 8;
    localparam int CH = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_HELD  = 2;

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic [CH*W-1:0] d = '0;
    logic [CH-1:0]   en = '0;
    logic [CH-1:0]   mode = '0;
    logic [CH-1:0]   arm = '0;
    logic [CH-1:0]   clear = '0;

    logic [CH*W-1:0] q_h3, q_h0;
    logic [CH-1:0]   armed_h3, armed_h0, held_h3, held_h0, cap_h3, cap_h0;
`ifdef D_LATCH_BANK_CHG_EN
    logic [CH-1:0]   chg_h3, chg_h0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Model state per instance (0: hold 3 cycles, 1: hold forever) and channel.
    int hold_of [2] = '{3, 0};
    int m_st   [2][CH];
    int m_q    [2][CH];
    int m_left [2][CH];
    int m_cap  [2][CH];
    int m_chg  [2][CH];

    always #5 clock = ~clock;

    d_latch_bank #(.WIDTH(W), .CHANNELS(CH), .HOLD_CYCLES(3)) u_dut_h3 (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (d),
        .en      (en),
        .mode    (mode),
        .arm     (arm),
        .clear   (clear),
        .q       (q_h3),
        .armed   (armed_h3),
        .held    (held_h3),
        .cap     (cap_h3)
`ifdef D_LATCH_BANK_CHG_EN
        ,
        .chg     (chg_h3)
`endif
    );

    d_latch_bank #(.WIDTH(W), .CHANNELS(CH), .HOLD_CYCLES(0)) u_dut_h0 (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (d),
        .en      (en),
        .mode    (mode),
        .arm     (arm),
        .clear   (clear),
        .q       (q_h0),
        .armed   (armed_h0),
        .held    (held_h0),
        .cap     (cap_h0)
`ifdef D_LATCH_BANK_CHG_EN
        ,
        .chg     (chg_h0)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < CH; c++) begin
                m_st[i][c]   = M_IDLE;
                m_q[i][c]    = 0;
                m_left[i][c] = 0;
                m_cap[i][c]  = 0;
                m_chg[i][c]  = 0;
            end
        end
    endtask

    // The model tracks "cycles of hold remaining" rather than an up-counter.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < CH; c++) begin
                int old_q;
                int dv;
                old_q = m_q[i][c];
                dv    = int'(d[c*W +: W]);
                m_cap[i][c] = 0;
                if (clear[c]) begin
                    m_st[i][c] = M_IDLE;
                    m_q[i][c]  = 0;
                end else if (!mode[c]) begin
                    m_st[i][c] = M_IDLE;
                    if (en[c]) m_q[i][c] = dv;
                end else if (m_st[i][c] == M_IDLE) begin
                    if (arm[c]) m_st[i][c] = M_ARMED;
                end else if (m_st[i][c] == M_ARMED) begin
                    if (!arm[c] && en[c]) begin
                        m_q[i][c]    = dv;
                        m_st[i][c]   = M_HELD;
                        m_left[i][c] = hold_of[i];
                        m_cap[i][c]  = 1;
                    end
                end else begin
                    if (arm[c]) begin
                        m_st[i][c] = M_ARMED;
                    end else if (hold_of[i] != 0) begin
                        m_left[i][c]--;
                        if (m_left[i][c] == 0) m_st[i][c] = M_IDLE;
                    end
                end
                m_chg[i][c] = (m_q[i][c] != old_q) ? 1 : 0;
            end
        end
    endtask

    task automatic check_all(input string phase);
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < CH; c++) begin
                logic [CH*W-1:0] qv;
                logic            av, hv, cv;
                qv = (i == 0) ? q_h3 : q_h0;
                av = (i == 0) ? armed_h3[c] : armed_h0[c];
                hv = (i == 0) ? held_h3[c] : held_h0[c];
                cv = (i == 0) ? cap_h3[c] : cap_h0[c];
                chk($sformatf("%s h%0d ch%0d q", phase, hold_of[i], c), 32'(qv[c*W +: W]), 32'(m_q[i][c]));
                chk($sformatf("%s h%0d ch%0d armed", phase, hold_of[i], c), 32'(av), 32'(m_st[i][c] == M_ARMED));
                chk($sformatf("%s h%0d ch%0d held", phase, hold_of[i], c), 32'(hv), 32'(m_st[i][c] == M_HELD));
                chk($sformatf("%s h%0d ch%0d cap", phase, hold_of[i], c), 32'(cv), 32'(m_cap[i][c]));
`ifdef D_LATCH_BANK_CHG_EN
                chk($sformatf("%s h%0d ch%0d chg", phase, hold_of[i], c),
                    32'((i == 0) ? chg_h3[c] : chg_h0[c]), 32'(m_chg[i][c]));
`endif
            end
        end
    endtask

    task automatic tick(input string phase);
        @(posedge clock);
        model_step();
        #1;
        check_all(phase);
    endtask

    task automatic set_d(input int c, input logic [W-1:0] v);
        d[c*W +: W] = v;
    endtask

    initial begin
        // Power-up reset, asserted as a real falling edge.
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("reset");
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;

        // Capture 0xA5 on ch0, then reset asynchronously between edges.
        mode = 4'b1111;
        arm[0] = 1'b1;                     tick("arm0");
        arm[0] = 1'b0; en[0] = 1'b1; set_d(0, 8'hA5); tick("cap0");
        en[0] = 1'b0;                      tick("held0");
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("async_reset");
        @(negedge clock) reset_n = 1'b1;

        // Follow mode on ch1.
        mode[1] = 1'b0; en[1] = 1'b1; set_d(1, 8'h3C); tick("follow_load");
        en[1] = 1'b0; set_d(1, 8'hFF);
        repeat (2) tick("follow_hold");

        // Capture and timeout on ch2, d wiggling during the hold.
        arm[2] = 1'b1;                     tick("arm2");
        arm[2] = 1'b0; en[2] = 1'b1; set_d(2, 8'h5A); tick("cap2");
        en[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_d(2, 8'($urandom));
            en[2] = 1'($urandom);
            tick("hold2");
        end
        en[2] = 1'b0;

        // Clear beats capture; arm beats capture from IDLE.
        arm[3] = 1'b1;                     tick("arm3");
        arm[3] = 1'b0; clear[3] = 1'b1; en[3] = 1'b1; set_d(3, 8'h77); tick("clear3");
        clear[3] = 1'b0; arm[3] = 1'b1; set_d(3, 8'h88); tick("arm_en3");
        arm[3] = 1'b0; en[3] = 1'b0;       tick("idle3");

        // Re-arm from HELD, then drop to follow mode.
        arm[0] = 1'b1;                     tick("arm0b");
        arm[0] = 1'b0; en[0] = 1'b1; set_d(0, 8'h11); tick("cap0b");
        en[0] = 1'b0; arm[0] = 1'b1;       tick("rearm0");
        arm[0] = 1'b0; mode[0] = 1'b0; en[0] = 1'b1; set_d(0, 8'h22); tick("follow0");
        en[0] = 1'b0;

        // Follow sequence 0x10, 0x10, 0x20 on ch1 for the change pulse.
        en[1] = 1'b1;
        set_d(1, 8'h10); tick("chg_a");
        set_d(1, 8'h10); tick("chg_b");
        set_d(1, 8'h20); tick("chg_c");
        en[1] = 1'b0;                      tick("chg_d");

        // Random traffic: mostly capture mode with occasional arm/clear.
        for (int k = 0; k < 300; k++) begin
            d = CH*W'($urandom);
            for (int c = 0; c < CH; c++) begin
                mode[c]  = ($urandom_range(0, 3) != 0);
                en[c]    = 1'($urandom);
                arm[c]   = ($urandom_range(0, 5) == 0);
                clear[c] = ($urandom_range(0, 19) == 0);
            end
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
